// File: rtl/spi_slave_24bit.sv
// spi_slave_24bit
// SPI responder for 24-bit frames: R/W bit, 7-bit register address, 16-bit data,
// MSB first. The SPI pins are oversampled in the clk domain. Writes and reads are
// presented to a local register bank as one-cycle strobes. Read data is shifted
// back on MISO during the 16 data bits.
// Parameters:
//   SAMPLE_EDGE  SCLK edge that samples MOSI (1 = rising, 0 = falling)
//   DRIVE_EDGE   SCLK edge that updates MISO (1 = rising, 0 = falling)
// Ports:
//   clk, resetn             system clock, synchronous active-low reset
//   SCLK, CS, MOSI          SPI inputs, asynchronous to clk
//   MISO, MISO_OE           serial read data and its output enable
//   reg_addr, reg_wdata     register address and write data
//   reg_we, reg_re          one-cycle write and read strobes
//   reg_rdata               read data, sampled one cycle after reg_re
//   busy                    frame in progress
//   frame_done, frame_err   one-cycle frame-end status pulses
module spi_slave_24bit #(
  parameter bit SAMPLE_EDGE = 1'b1,
  parameter bit DRIVE_EDGE  = 1'b0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        SCLK,
  input  logic        CS,
  input  logic        MOSI,
  output logic        MISO,
  output logic        MISO_OE,
  output logic [6:0]  reg_addr,
  output logic [15:0] reg_wdata,
  output logic        reg_we,
  output logic        reg_re,
  input  logic [15:0] reg_rdata,
  output logic        busy,
  output logic        frame_done,
  output logic        frame_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  sclk_sync_q, sclk_sync_d;
  logic [2:0]  cs_sync_q, cs_sync_d;
  logic [1:0]  mosi_sync_q, mosi_sync_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        overrun_q, overrun_d;
  // Only 23 bits are kept: the R/W bit is still visible as rx_shift_s[23]
  // on the 24th sample edge, which is the only place it is needed.
  logic [22:0] rx_q, rx_d;
  logic [15:0] tx_q, tx_d;
  logic        is_read_q, is_read_d;
  logic        rd_load_q, rd_load_d;
  logic        miso_q, miso_d;
  logic        busy_q, busy_d;
  logic [6:0]  reg_addr_q, reg_addr_d;
  logic [15:0] reg_wdata_q, reg_wdata_d;
  logic        reg_we_q, reg_we_d;
  logic        reg_re_q, reg_re_d;
  logic        frame_done_q, frame_done_d;
  logic        frame_err_q, frame_err_d;

  logic        sclk_rise_s, sclk_fall_s, cs_rise_s, cs_fall_s;
  logic        sample_edge_s, drive_edge_s;
  logic [23:0] rx_shift_s;

  assign sclk_rise_s   = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclk_fall_s   = ~sclk_sync_q[1] & sclk_sync_q[2];
  assign cs_rise_s     = cs_sync_q[1] & ~cs_sync_q[2];
  assign cs_fall_s     = ~cs_sync_q[1] & cs_sync_q[2];
  assign sample_edge_s = SAMPLE_EDGE ? sclk_rise_s : sclk_fall_s;
  assign drive_edge_s  = DRIVE_EDGE ? sclk_rise_s : sclk_fall_s;
  assign rx_shift_s    = {rx_q, mosi_sync_q[1]};

  // Next-state logic: synchronizers, frame FSM, shifters and strobes.
  always_comb begin
    sclk_sync_d  = {sclk_sync_q[1:0], SCLK};
    cs_sync_d    = {cs_sync_q[1:0], CS};
    mosi_sync_d  = {mosi_sync_q[0], MOSI};
    state_d      = state_q;
    cnt_d        = cnt_q;
    overrun_d    = overrun_q;
    rx_d         = rx_q;
    tx_d         = tx_q;
    is_read_d    = is_read_q;
    miso_d       = miso_q;
    reg_addr_d   = reg_addr_q;
    reg_wdata_d  = reg_wdata_q;
    reg_we_d     = 1'b0;
    reg_re_d     = 1'b0;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;
    // reg_rdata is captured the cycle after reg_re has been presented.
    rd_load_d    = reg_re_q;

    if (cs_rise_s && (state_q != ST_IDLE)) begin
      state_d   = ST_IDLE;
      miso_d    = 1'b0;
      rd_load_d = 1'b0;
      if ((cnt_q == 5'd24) && !overrun_q) begin
        frame_done_d = 1'b1;
      end else begin
        frame_err_d = 1'b1;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          miso_d = 1'b0;
          // A sample edge coinciding with the CS falling edge is dropped here.
          if (cs_fall_s) begin
            state_d   = ST_ADDR;
            cnt_d     = 5'd0;
            tx_d      = 16'd0;
            overrun_d = 1'b0;
            is_read_d = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_ADDR: begin
          if (sample_edge_s) begin
            rx_d  = rx_shift_s[22:0];
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd7) begin
              state_d    = ST_DATA;
              is_read_d  = rx_shift_s[7];
              reg_addr_d = rx_shift_s[6:0];
              reg_re_d   = rx_shift_s[7];
            end else begin
              state_d = ST_ADDR;
            end
          end else begin
            state_d = ST_ADDR;
          end
        end
        ST_DATA: begin
          if (rd_load_q) begin
            tx_d = reg_rdata;
          end else if (drive_edge_s && is_read_q) begin
            miso_d = tx_q[15];
            tx_d   = {tx_q[14:0], 1'b0};
          end else begin
            tx_d = tx_q;
          end
          if (sample_edge_s) begin
            rx_d  = rx_shift_s[22:0];
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd23) begin
              state_d = ST_DONE;
              if (!rx_shift_s[23]) begin
                reg_we_d    = 1'b1;
                reg_addr_d  = rx_shift_s[22:16];
                reg_wdata_d = rx_shift_s[15:0];
              end else begin
                reg_we_d = 1'b0;
              end
            end else begin
              state_d = ST_DATA;
            end
          end else begin
            state_d = ST_DATA;
          end
        end
        ST_DONE: begin
          // tx has been emptied by now, so trailing drive edges shift out 0.
          if (drive_edge_s && is_read_q) begin
            miso_d = tx_q[15];
            tx_d   = {tx_q[14:0], 1'b0};
          end else begin
            tx_d = tx_q;
          end
          if (sample_edge_s) begin
            overrun_d = 1'b1;
          end else begin
            overrun_d = overrun_q;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers. The CS synchronizer resets to "low" so a CS
  // held low across reset release cannot look like a falling edge.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sclk_sync_q  <= 3'b000;
      cs_sync_q    <= 3'b000;
      mosi_sync_q  <= 2'b00;
      state_q      <= ST_IDLE;
      cnt_q        <= 5'd0;
      overrun_q    <= 1'b0;
      rx_q         <= 23'd0;
      tx_q         <= 16'd0;
      is_read_q    <= 1'b0;
      rd_load_q    <= 1'b0;
      miso_q       <= 1'b0;
      busy_q       <= 1'b0;
      reg_addr_q   <= 7'd0;
      reg_wdata_q  <= 16'd0;
      reg_we_q     <= 1'b0;
      reg_re_q     <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      sclk_sync_q  <= sclk_sync_d;
      cs_sync_q    <= cs_sync_d;
      mosi_sync_q  <= mosi_sync_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      overrun_q    <= overrun_d;
      rx_q         <= rx_d;
      tx_q         <= tx_d;
      is_read_q    <= is_read_d;
      rd_load_q    <= rd_load_d;
      miso_q       <= miso_d;
      busy_q       <= busy_d;
      reg_addr_q   <= reg_addr_d;
      reg_wdata_q  <= reg_wdata_d;
      reg_we_q     <= reg_we_d;
      reg_re_q     <= reg_re_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign MISO       = miso_q;
  assign MISO_OE    = busy_q;
  assign busy       = busy_q;
  assign reg_addr   = reg_addr_q;
  assign reg_wdata  = reg_wdata_q;
  assign reg_we     = reg_we_q;
  assign reg_re     = reg_re_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_spi_slave_24bit.sv
// Testbench for spi_slave_24bit. Two instances run side by side: dut0 samples on
// rising SCLK and drives on falling, dut1 uses the opposite edges and receives
// the inverted SCLK, so both see the same logical frames. A reference model
// predicts each frame's strobes and the MISO word the master should capture;
// a monitor pops and compares whenever a DUT raises a strobe.
`timescale 1ns/1ps
module tb_spi_slave_24bit;

  localparam int K_RE   = 0;
  localparam int K_WE   = 1;
  localparam int K_DONE = 2;
  localparam int K_ERR  = 3;

  typedef struct {
    int          kind;
    logic [6:0]  addr;
    logic [15:0] data;
    logic [31:0] cap;
  } ev_t;

  logic        clk = 1'b0;
  logic        resetn, sclk, sclk_n, cs, mosi;
  logic [15:0] rdata_v;
  logic [1:0]  miso, oe, we, re, busy, done, err;
  logic [6:0]  raddr0, raddr1;
  logic [15:0] wdata0, wdata1;
  logic [31:0] cap0, cap1;

  ev_t q0[$];
  ev_t q1[$];
  int  n_checks = 0;
  int  n_pass   = 0;

  always #5 clk = ~clk;
  assign sclk_n = ~sclk;

  spi_slave_24bit #(.SAMPLE_EDGE(1'b1), .DRIVE_EDGE(1'b0)) dut0 (
    .clk(clk), .resetn(resetn), .SCLK(sclk), .CS(cs), .MOSI(mosi),
    .MISO(miso[0]), .MISO_OE(oe[0]), .reg_addr(raddr0), .reg_wdata(wdata0),
    .reg_we(we[0]), .reg_re(re[0]), .reg_rdata(rdata_v), .busy(busy[0]),
    .frame_done(done[0]), .frame_err(err[0])
  );

  spi_slave_24bit #(.SAMPLE_EDGE(1'b0), .DRIVE_EDGE(1'b1)) dut1 (
    .clk(clk), .resetn(resetn), .SCLK(sclk_n), .CS(cs), .MOSI(mosi),
    .MISO(miso[1]), .MISO_OE(oe[1]), .reg_addr(raddr1), .reg_wdata(wdata1),
    .reg_we(we[1]), .reg_re(re[1]), .reg_rdata(rdata_v), .busy(busy[1]),
    .frame_done(done[1]), .frame_err(err[1])
  );

  task automatic push(input int kind, input logic [6:0] a, input logic [15:0] d,
                      input logic [31:0] c);
    ev_t e;
    e.kind = kind; e.addr = a; e.data = d; e.cap = c;
    q0.push_back(e);
    q1.push_back(e);
  endtask

  task automatic pop_cmp(input int i, input int kind, input logic [6:0] a,
                         input logic [15:0] d, input logic [31:0] c);
    ev_t e;
    bit  ok;
    bit  empty;
    n_checks++;
    empty = (i == 0) ? (q0.size() == 0) : (q1.size() == 0);
    if (empty) begin
      $display("FAIL dut%0d unexpected_event: got kind=%0d addr=%h data=%h cap=%h, required none",
               i, kind, a, d, c);
    end else begin
      if (i == 0) e = q0.pop_front();
      else        e = q1.pop_front();
      ok = (e.kind == kind);
      if (kind == K_RE)  ok = ok && (a == e.addr);
      if (kind == K_WE)  ok = ok && (a == e.addr) && (d == e.data);
      if (kind == K_DONE || kind == K_ERR) ok = ok && (c == e.cap);
      if (ok) n_pass++;
      else $display("FAIL dut%0d event: got kind=%0d addr=%h data=%h cap=%h, required kind=%0d addr=%h data=%h cap=%h",
                    i, kind, a, d, c, e.kind, e.addr, e.data, e.cap);
    end
  endtask

  task automatic mon(input int i, input logic r, input logic w, input logic dn,
                     input logic er, input logic [6:0] a, input logic [15:0] d,
                     input logic [31:0] c);
    if (r)  pop_cmp(i, K_RE, a, 16'h0000, 32'h0);
    if (w)  pop_cmp(i, K_WE, a, d, 32'h0);
    if (dn) pop_cmp(i, K_DONE, 7'h00, 16'h0000, c);
    if (er) pop_cmp(i, K_ERR, 7'h00, 16'h0000, c);
  endtask

  // Monitor: compare every strobe/status pulse away from the active edge.
  always @(negedge clk) begin
    if (resetn === 1'b1) begin
      mon(0, re[0], we[0], done[0], err[0], raddr0, wdata0, cap0);
      mon(1, re[1], we[1], done[1], err[1], raddr1, wdata1, cap1);
    end
  end

  task automatic check_empty(input string name);
    n_checks++;
    if (q0.size() == 0 && q1.size() == 0) n_pass++;
    else $display("FAIL %s pending_events: got dut0=%0d dut1=%0d outstanding, required 0",
                  name, q0.size(), q1.size());
  endtask

  task automatic check_reset(input string name);
    logic [29:0] act;
    for (int i = 0; i < 2; i++) begin
      act = {(i == 0) ? raddr0 : raddr1, (i == 0) ? wdata0 : wdata1,
             miso[i], oe[i], we[i], re[i], busy[i], done[i], err[i]};
      n_checks++;
      if (act == 30'd0) n_pass++;
      else $display("FAIL %s dut%0d reset_outputs: got %h, required 0", name, i, act);
    end
  endtask

  // SPI master: nbits clocks, bits beyond 24 are 1s; MISO captured on the sample edge.
  task automatic spi_frame(input logic [23:0] fr, input int nbits, input bit raise_cs);
    cs = 1'b0; cap0 = 32'h0; cap1 = 32'h0;
    for (int k = 0; k < nbits; k++) begin
      mosi = (k < 24) ? fr[23 - k] : 1'b1;
      repeat (5) @(negedge clk);
      sclk = 1'b1;
      cap0 = {cap0[30:0], miso[0]};
      cap1 = {cap1[30:0], miso[1]};
      repeat (5) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (5) @(negedge clk);
    if (raise_cs) begin
      cs = 1'b1;
      repeat (10) @(negedge clk);
    end
  endtask

  // Reference model: predict the frame's events, then play it.
  task automatic run_frame(input bit rd, input logic [6:0] a, input logic [15:0] d,
                           input int nbits, input logic [15:0] rv);
    logic [31:0] ecap;
    logic        b;
    rdata_v = rv;
    ecap = 32'h0;
    for (int k = 0; k < nbits; k++) begin
      b = (rd && k >= 8 && k < 24) ? rv[23 - k] : 1'b0;
      ecap = {ecap[30:0], b};
    end
    if (rd && nbits >= 8)   push(K_RE, a, 16'h0000, 32'h0);
    if (!rd && nbits >= 24) push(K_WE, a, d, 32'h0);
    push((nbits == 24) ? K_DONE : K_ERR, 7'h00, 16'h0000, ecap);
    spi_frame({rd, a, d}, nbits, 1'b1);
    check_empty("frame");
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          r, nb;
    logic [15:0] rnd16;
    resetn = 1'b0; cs = 1'b1; sclk = 1'b0; mosi = 1'b0; rdata_v = 16'h0000;
    cap0 = 32'h0; cap1 = 32'h0;
    repeat (4) @(negedge clk);
    check_reset("reset");
    resetn = 1'b1;
    repeat (6) @(negedge clk);

    // Directed cases
    rnd16 = 16'($urandom);
    run_frame(1'b0, 7'h2A, 16'h1234, 24, rnd16);
    run_frame(1'b1, 7'h01, 16'h0000, 24, 16'hBEEF);
    run_frame(1'b0, 7'h05, 16'hFFFF, 10, 16'h0000);
    run_frame(1'b0, 7'h11, 16'h5A5A, 24, 16'h0000);
    run_frame(1'b0, 7'h10, 16'hA5A5, 26, 16'h0000);

    // Reset in the middle of a frame, CS still low at release
    spi_frame({1'b0, 7'h33, 16'hCAFE}, 12, 1'b0);
    n_checks++;
    if (busy == 2'b11 && oe == 2'b11) n_pass++;
    else $display("FAIL midframe_busy: got busy=%b oe=%b, required 11/11", busy, oe);
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("midreset");
    resetn = 1'b1;
    repeat (6) @(negedge clk);
    cs = 1'b1;
    repeat (10) @(negedge clk);
    check_empty("after_reset");
    run_frame(1'b0, 7'h03, 16'h0001, 24, 16'h0000);

    // Randomized frames
    for (int n = 0; n < 30; n++) begin
      r = $urandom_range(0, 9);
      if (r < 7)       nb = 24;
      else if (r == 7) nb = $urandom_range(0, 23);
      else             nb = $urandom_range(25, 28);
      run_frame(1'($urandom_range(0, 1)), 7'($urandom), 16'($urandom), nb, 16'($urandom));
    end

    repeat (20) @(negedge clk);
    check_empty("final");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
